mem_fifo_loader: RTL and testbench
==================================

# mem_fifo_loader

Fill-stage controller for the matrix-vector datapath. It reads packed 64-bit words from the Avalon-MM memory wrapper (address 0 is the B vector, addresses 1..NUM_ROWS are the rows of matrix A), unpacks each word into bytes, and writes them in order into the B FIFO and the NUM_ROWS A FIFOs. It sits directly upstream of the FIFO/MAC array and reports `done` once every FIFO has received its full row.

## Interface
- DATA_WIDTH, 8: byte width of one FIFO entry.
- NUM_ROWS, 8: number of A rows and A FIFOs.
- WORD_BYTES, 8: bytes per memory word; readdata width is DATA_WIDTH*WORD_BYTES.
- ADDR_WIDTH, 32: memory address width.

- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- address  out  ADDR_WIDTH  word address to memory.
- read  out  1  Avalon read request.
- readdata  in  DATA_WIDTH*WORD_BYTES  returned word; byte 0 is bits [7:0].
- readdatavalid  in  1  readdata valid this cycle.
- waitrequest  in  1  memory stall; a read is accepted when read=1 and waitrequest=0.
- fifo_data  out  DATA_WIDTH  byte to write; shared by all FIFOs.
- fifo_wrreq  out  NUM_ROWS+1  one-hot write strobe; bit 0 = B FIFO, bit k = A row k-1.
- fifo_full  in  NUM_ROWS+1  full flags, same indexing as fifo_wrreq.
- busy  out  1  high from leaving IDLE until entering DONE.
- done  out  1  one-cycle pulse when the last byte has been written.

## Operation
- States: IDLE, REQ, WAIT_DATA, DRAIN, DONE.
- IDLE: address=0, read=0. When start=1, go to REQ with word index w=0.
- REQ: read=1, address=w. Hold both stable while waitrequest=1. On acceptance, go to WAIT_DATA. If readdatavalid also arrives in the acceptance cycle, capture the word and go directly to DRAIN.
- WAIT_DATA: read=0. On readdatavalid, capture readdata into the unpack register, clear byte count b, and go to DRAIN.
- DRAIN: target FIFO index is w. fifo_data = current low byte. fifo_wrreq[w] = ~fifo_full[w] (combinational from state and the full flag). On each write, shift right by DATA_WIDTH and increment b.
  - After write WORD_BYTES-1: if w==NUM_ROWS, go to DONE. Otherwise increment w and go to REQ.
- DONE: done=1 for one cycle, then IDLE.
- Only one read is ever outstanding. readdatavalid outside WAIT_DATA and the REQ acceptance cycle is ignored.
- start while busy is ignored. No restart occurs mid-load.
- address width rule: w is zero-extended to ADDR_WIDTH. w never exceeds NUM_ROWS, so there is no wrap-around.

## Timing
- Reset values: address=0, read=0, fifo_data=0, fifo_wrreq=0, busy=0, done=0, state=IDLE.
- start (cycle 0) -> read=1 in cycle 1.
- Per word, with no stalls: 1 request cycle + memory latency L + WORD_BYTES write cycles.
- Full load, with no stalls and no waitrequest: (NUM_ROWS+1)*(1+L+WORD_BYTES) cycles, +1 for DONE.
- FIFO full: the write is held and the byte is not consumed. The write resumes the cycle full deasserts, and byte order is preserved.
- Bytes are written in order byte0 first, at most one byte per cycle, and never to more than one FIFO in the same cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous reset). The captured word and all counters are discarded. A fresh start is required after reset.

## Structure
- Shared package `minilab_pkg`:
  - DATA_WIDTH, NUM_ROWS, WORD_BYTES defaults.
  - `loader_state_t` enum.
  - B_FIFO_IDX=0.
- Sub-module `word_unpacker`: a 64-bit load/shift register plus byte counter.
  - Inputs: load, shift.
  - Outputs: byte_out, last.
- The FSM and word index stay in mem_fifo_loader.

## Test plan
- Address 0 holds 64'h0807060504030201, L=1, no stalls -> B FIFO receives 01,02,…,08 in order. fifo_wrreq[0] is high for exactly 8 consecutive cycles.
- Address k holds {8{k[7:0]}} for k=1..8 -> A FIFO k-1 receives eight copies of k. done pulses once, at cycle 9*(1+1+8)+1 after start. busy then falls.
- waitrequest held high for 3 cycles at address 4 -> read and address=4 stay stable for 4 cycles. The data loaded is unchanged.
- fifo_full[2] asserted for 5 cycles after the 3rd byte of row 1 -> wrreq is suppressed for those cycles. Bytes 4..8 follow afterwards with no loss or duplication.
- Zero-latency memory (readdatavalid in the acceptance cycle) -> no WAIT_DATA cycle. Total load is 9*9+1 cycles. Contents are correct.
- Two further scenarios:
  - rst_n pulsed low mid-DRAIN of row 5 -> all outputs are 0 in the same cycle and the block returns to IDLE. After a new start, the load begins again at address 0.
  - A second start pulse while busy -> no effect, and a single done pulse.

Source files
------------

// File: rtl/minilab_pkg.sv
// Shared constants and types for the matrix-vector fill stage.
package minilab_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int NUM_ROWS   = 8;
   localparam int WORD_BYTES = 8;
   localparam int ADDR_WIDTH = 32;
   localparam int B_FIFO_IDX = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_DATA,
      ST_DRAIN,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/mem_fifo_loader_word_unpacker.sv
// Holds one memory word and hands it out one byte at a time, low byte first.
module word_unpacker #(
   parameter int DATA_WIDTH = minilab_pkg::DATA_WIDTH,
   parameter int WORD_BYTES = minilab_pkg::WORD_BYTES
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load,
   input  logic                             shift,
   input  logic [DATA_WIDTH*WORD_BYTES-1:0] word,
   output logic [DATA_WIDTH-1:0]            byte_out,
   output logic                             last
);

   localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   logic [DATA_WIDTH*WORD_BYTES-1:0] word_q;
   logic [CNT_W-1:0]                 cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         word_q <= word;
         cnt_q  <= '0;
      end else if (shift) begin
         word_q <= word_q >> DATA_WIDTH;
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign byte_out = word_q[DATA_WIDTH-1:0];
   assign last     = (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/mem_fifo_loader.sv
// Reads the B vector and A rows from memory and streams their bytes into the FIFO array.
module mem_fifo_loader #(
   parameter int DATA_WIDTH = minilab_pkg::DATA_WIDTH,
   parameter int NUM_ROWS   = minilab_pkg::NUM_ROWS,
   parameter int WORD_BYTES = minilab_pkg::WORD_BYTES,
   parameter int ADDR_WIDTH = minilab_pkg::ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic [ADDR_WIDTH-1:0]            address,
   output logic                             read,
   input  logic [DATA_WIDTH*WORD_BYTES-1:0] readdata,
   input  logic                             readdatavalid,
   input  logic                             waitrequest,
   output logic [DATA_WIDTH-1:0]            fifo_data,
   output logic [NUM_ROWS:0]                fifo_wrreq,
   input  logic [NUM_ROWS:0]                fifo_full,
   output logic                             busy,
   output logic                             done
);
   import minilab_pkg::*;

   localparam int FIFO_N = NUM_ROWS + 1;
   localparam int W_W    = (FIFO_N > 1) ? $clog2(FIFO_N) : 1;

   loader_state_t          state_q;
   logic [W_W-1:0]         w_q;
   logic                   load_word;
   logic                   wr_en;
   logic                   last_byte;
   logic [DATA_WIDTH-1:0]  byte_cur;

   // A word may be captured in the acceptance cycle itself (zero-latency memory).
   assign load_word = readdatavalid &&
                      (((state_q == ST_REQ) && !waitrequest) || (state_q == ST_WAIT_DATA));
   assign wr_en     = (state_q == ST_DRAIN) && !fifo_full[w_q];

   word_unpacker #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_BYTES (WORD_BYTES)
   ) u_unpack (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_word),
      .shift    (wr_en),
      .word     (readdata),
      .byte_out (byte_cur),
      .last     (last_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         w_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  w_q     <= W_W'(B_FIFO_IDX);
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!waitrequest) state_q <= readdatavalid ? ST_DRAIN : ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
               if (readdatavalid) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (wr_en && last_byte) begin
                  if (w_q == W_W'(NUM_ROWS)) begin
                     state_q <= ST_DONE;
                  end else begin
                     w_q     <= w_q + 1'b1;
                     state_q <= ST_REQ;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      fifo_wrreq = '0;
      if (wr_en) fifo_wrreq[w_q] = 1'b1;
   end

   assign read      = (state_q == ST_REQ);
   assign address   = read ? {{(ADDR_WIDTH-W_W){1'b0}}, w_q} : '0;
   assign fifo_data = byte_cur;
   assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT_DATA) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Scoreboard bench for mem_fifo_loader with a small Avalon memory and FIFO-full model.
module tb_mem_fifo_loader;
   import minilab_pkg::*;

   localparam int NF = NUM_ROWS + 1;
   localparam int WB = DATA_WIDTH * WORD_BYTES;

   logic                  clk   = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [ADDR_WIDTH-1:0] address;
   logic                  read;
   logic [WB-1:0]         readdata;
   logic                  readdatavalid;
   logic                  waitrequest;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic [NF-1:0]         fifo_wrreq;
   logic [NF-1:0]         fifo_full;
   logic                  busy;
   logic                  done;

   typedef struct packed {
      logic [3:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t                  sb[$];
   logic [WB-1:0]         mem [NF];
   int                    checks = 0;
   int                    failures = 0;
   int                    cyc = 0;
   int                    lat = 1;
   logic [ADDR_WIDTH-1:0] stall_addr = '0;
   int                    stall_len = 0;
   int                    stall_used = 0;
   int                    full_at = -1;
   int                    wr2_cnt = 0;
   int                    full2_cnt = 0;
   logic                  pend_q = 1'b0;
   logic [WB-1:0]         pend_data_q = '0;
   int                    b_cnt = 0;
   int                    b_run = 0;
   int                    rd4_cnt = 0;
   logic                  prev_b = 1'b0;

   mem_fifo_loader #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_ROWS   (NUM_ROWS),
      .WORD_BYTES (WORD_BYTES),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .address       (address),
      .read          (read),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .fifo_data     (fifo_data),
      .fifo_wrreq    (fifo_wrreq),
      .fifo_full     (fifo_full),
      .busy          (busy),
      .done          (done)
   );

   function automatic logic [WB-1:0] mem_rd(input logic [ADDR_WIDTH-1:0] a);
      if (a < NF) return mem[int'(a)];
      return '0;
   endfunction

   always #5 clk = ~clk;

   assign waitrequest   = read && (address == stall_addr) && (stall_used < stall_len);
   assign readdatavalid = (lat == 0) ? (read && !waitrequest) : pend_q;
   assign readdata      = (lat == 0) ? mem_rd(address) : pend_data_q;
   assign fifo_full     = (full2_cnt > 0) ? NF'(4) : '0;

   // Memory with one-cycle latency plus the injected stall and FIFO-full windows.
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      pend_q      <= (lat != 0) && read && !waitrequest;
      pend_data_q <= mem_rd(address);
      if (waitrequest) stall_used <= stall_used + 1;
      if (fifo_wrreq[2]) begin
         wr2_cnt <= wr2_cnt + 1;
         if (wr2_cnt + 1 == full_at) full2_cnt <= 5;
      end else if (full2_cnt > 0) begin
         full2_cnt <= full2_cnt - 1;
      end
   end

   task automatic push_load();
      exp_t e;
      for (int w = 0; w < NF; w++) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            e.idx  = 4'(w);
            e.data = mem[w][8*b +: 8];
            sb.push_back(e);
         end
      end
   endtask

   task automatic start_load(output int t0);
      @(negedge clk);
      start   = 1'b1;
      t0      = cyc;
      b_cnt   = 0;
      b_run   = 0;
      prev_b  = 1'b0;
      rd4_cnt = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic watch(input int budget, input int stop_idx, input int pulse_cyc,
                        output int done_at);
      logic [3:0] got;
      exp_t       e;
      logic       stop;
      done_at = -1;
      stop    = 1'b0;
      for (int i = 0; i < budget && !stop; i++) begin
         @(negedge clk);
         start = (cyc == pulse_cyc);
         if (fifo_wrreq != '0) begin
            got = '0;
            for (int k = 0; k < NF; k++) if (fifo_wrreq[k]) got = 4'(k);
            checks++;
            if (!$onehot(fifo_wrreq) || ((fifo_wrreq & fifo_full) != '0) || (sb.size() == 0)) begin
               failures++;
               $display("FAIL fifo_write cyc=%0d got wrreq=%b full=%b data=%h required one-hot unfull write with %0d bytes pending",
                        cyc, fifo_wrreq, fifo_full, fifo_data, sb.size());
            end else begin
               e = sb.pop_front();
               if (got !== e.idx || fifo_data !== e.data) begin
                  failures++;
                  $display("FAIL fifo_byte cyc=%0d got fifo=%0d data=%h required fifo=%0d data=%h",
                           cyc, got, fifo_data, e.idx, e.data);
               end
            end
         end
         if (fifo_wrreq[0]) begin
            b_cnt++;
            b_run = prev_b ? b_run + 1 : 1;
         end
         prev_b = fifo_wrreq[0];
         if (read && address == 4) rd4_cnt++;
         if (done) begin
            done_at = cyc;
            stop    = 1'b1;
         end
         if (stop_idx >= 0 && stop_idx < NF && fifo_wrreq[stop_idx]) stop = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic check_after(input string name);
      int d;
      watch(10, -1, -1, d);
      checks++;
      if (d != -1 || busy !== 1'b0 || read !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL %s_after got extra_done_cyc=%0d busy=%b read=%b pending=%0d required none,0,0,0",
                  name, d, busy, read, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({address, read, fifo_data, fifo_wrreq, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got address=%h read=%b data=%h wrreq=%b busy=%b done=%b required all 0",
                  address, read, fifo_data, fifo_wrreq, busy, done);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (read !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got read=%b busy=%b done=%b required 0 0 0", read, busy, done);
      end
   endtask

   task automatic test_basic();
      int t0, d;
      push_load();
      start_load(t0);
      checks++;
      if (read !== 1'b1 || address !== '0) begin
         failures++;
         $display("FAIL first_read got read=%b address=%h required 1 0", read, address);
      end
      watch(300, -1, -1, d);
      checks++;
      if (d - t0 != 91 || d < 0) begin
         failures++;
         $display("FAIL basic_done_time got %0d required 91", (d < 0) ? -1 : d - t0);
      end
      checks++;
      if (b_cnt != 8 || b_run != 8) begin
         failures++;
         $display("FAIL b_fifo_run got count=%0d run=%0d required 8 8", b_cnt, b_run);
      end
      check_after("basic");
   endtask

   task automatic test_stall();
      int t0, d;
      stall_addr = 4;
      stall_len  = 3;
      push_load();
      start_load(t0);
      watch(300, -1, -1, d);
      checks++;
      if (d - t0 != 94 || d < 0) begin
         failures++;
         $display("FAIL stall_done_time got %0d required 94", (d < 0) ? -1 : d - t0);
      end
      checks++;
      if (rd4_cnt != 4) begin
         failures++;
         $display("FAIL stall_read_cycles got %0d required 4", rd4_cnt);
      end
      check_after("stall");
   endtask

   task automatic test_full();
      int t0, d;
      full_at = wr2_cnt + 3;
      push_load();
      start_load(t0);
      watch(300, -1, -1, d);
      checks++;
      if (d - t0 != 96 || d < 0) begin
         failures++;
         $display("FAIL full_done_time got %0d required 96", (d < 0) ? -1 : d - t0);
      end
      check_after("full");
   endtask

   task automatic test_zero_latency();
      int t0, d;
      lat = 0;
      push_load();
      start_load(t0);
      watch(300, -1, -1, d);
      checks++;
      if (d - t0 != 82 || d < 0) begin
         failures++;
         $display("FAIL zero_lat_done_time got %0d required 82", (d < 0) ? -1 : d - t0);
      end
      check_after("zero_lat");
      lat = 1;
   endtask

   task automatic test_mid_reset();
      int t0, d;
      push_load();
      start_load(t0);
      watch(300, 6, -1, d);
      checks++;
      if (fifo_wrreq[6] !== 1'b1) begin
         failures++;
         $display("FAIL reach_row5 got wrreq=%b required bit 6 set", fifo_wrreq);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({address, read, fifo_data, fifo_wrreq, busy, done} !== '0) begin
         failures++;
         $display("FAIL async_reset got address=%h read=%b data=%h wrreq=%b busy=%b done=%b required all 0",
                  address, read, fifo_data, fifo_wrreq, busy, done);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (read !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL no_self_restart got read=%b busy=%b required 0 0", read, busy);
      end
      push_load();
      start_load(t0);
      checks++;
      if (read !== 1'b1 || address !== '0) begin
         failures++;
         $display("FAIL restart_address got read=%b address=%h required 1 0", read, address);
      end
      watch(300, -1, -1, d);
      checks++;
      if (d - t0 != 91 || d < 0) begin
         failures++;
         $display("FAIL restart_done_time got %0d required 91", (d < 0) ? -1 : d - t0);
      end
      check_after("restart");
   endtask

   task automatic test_double_start();
      int t0, d;
      push_load();
      start_load(t0);
      watch(300, -1, t0 + 30, d);
      checks++;
      if (d - t0 != 91 || d < 0) begin
         failures++;
         $display("FAIL dbl_start_done_time got %0d required 91", (d < 0) ? -1 : d - t0);
      end
      check_after("dbl_start");
   endtask

   initial begin
      mem[0] = 64'h0807060504030201;
      for (int k = 1; k < NF; k++) mem[k] = {WORD_BYTES{k[7:0]}};
      test_reset();
      test_basic();
      test_stall();
      test_full();
      test_zero_latency();
      test_mid_reset();
      test_double_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
